// File: rtl/udp_tx_packetizer_if.sv
// Signal bundle between the user byte stream, the packetizer and the UDP stack send port.
// The slave modport is the packetizer's view; the master modport is the surrounding system's view.
interface udp_tx_packetizer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        i_flush;
    logic [7:0]  o_send_udp_data;
    logic [15:0] o_send_udp_len;
    logic        o_send_udp_last;
    logic        o_send_udp_valid;
    logic        i_send_ready;
    logic [15:0] o_frame_cnt;

    modport slave (
        input  s_data, s_valid, i_flush, i_send_ready,
        output s_ready, o_send_udp_data, o_send_udp_len, o_send_udp_last,
               o_send_udp_valid, o_frame_cnt
    );

    modport master (
        output s_data, s_valid, i_flush, i_send_ready,
        input  s_ready, o_send_udp_data, o_send_udp_len, o_send_udp_last,
               o_send_udp_valid, o_frame_cnt
    );
endinterface

// File: rtl/udp_tx_packetizer.sv
// Buffers a user byte stream and cuts it into UDP payload frames bounded by P_MAX_LEN,
// emitting a partial frame on idle timeout or on a flush request.
module udp_tx_packetizer_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        valid,
    input logic        last,
    input logic [15:0] len
);
    // A frame end marker is only meaningful on a valid byte
    assert property (@(posedge clk) disable iff (!rst_n) last |-> valid);
    // The length field is quiet between frames
    assert property (@(posedge clk) disable iff (!rst_n) !valid |-> (len == 16'h0000));
endmodule

module udp_tx_packetizer #(
    parameter int P_MAX_LEN    = 1024,
    parameter int P_TIMEOUT    = 1000,
    parameter int P_FIFO_DEPTH = 2048
) (
    input logic                i_clk,
    input logic                i_rst,
    udp_tx_packetizer_if.slave bus
);
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(P_FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_CNT   = CW'(P_MAX_LEN);
    localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_PTR  = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_PTR   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   MAX_LEN16 = 16'(P_MAX_LEN);
    localparam logic [15:0]   TIMEOUT16 = 16'(P_TIMEOUT);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [1:0] ST_SEND     = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    logic [7:0]    mem_r [P_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          ready_r;
    logic [15:0]   timer_r;
    logic [15:0]   frame_len_r;
    logic [15:0]   sent_r;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          start_s;
    logic          last_rd_s;
    logic [7:0]    data_r;
    logic [15:0]   len_r;
    logic          last_r;
    logic          valid_r;
    logic [15:0]   frame_cnt_r;

    assign wr_en_s   = bus.s_valid & ready_r;
    assign rd_en_s   = (state_r == ST_SEND);
    assign last_rd_s = rd_en_s && (sent_r == (frame_len_r - 16'd1));

    // Buffer occupancy after this cycle's write and read
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
    end

    // Frame launch: full frame available, idle timeout, or flush request on a non-empty buffer
    always_comb begin
        start_s = 1'b0;
        if (count_r != ZERO_CNT) begin
            start_s = (count_r >= MAX_CNT) || (timer_r == TIMEOUT16) || bus.i_flush;
        end else begin
            start_s = 1'b0;
        end
    end

    // Frame sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_WAIT_RDY;
                else         state_nxt_s = ST_IDLE;
            end
            ST_WAIT_RDY: begin
                if (bus.i_send_ready) state_nxt_s = ST_SEND;
                else                  state_nxt_s = ST_WAIT_RDY;
            end
            ST_SEND: begin
                if (last_rd_s) state_nxt_s = ST_GAP;
                else           state_nxt_s = ST_SEND;
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Payload storage; contents need no reset because the pointers define validity
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.s_data;
        end
    end

    // Buffer pointers, occupancy, idle timer and frame bookkeeping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_r    <= ZERO_PTR;
            rd_ptr_r    <= ZERO_PTR;
            count_r     <= ZERO_CNT;
            ready_r     <= 1'b0;
            timer_r     <= 16'd0;
            state_r     <= ST_IDLE;
            frame_len_r <= 16'd0;
            sent_r      <= 16'd0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + ONE_PTR;
            count_r <= count_nxt_s;
            // Registered so that it stays low through reset and reflects the post-edge occupancy
            ready_r <= (count_nxt_s < DEPTH_CNT);
            if (wr_en_s || (count_r == ZERO_CNT)) begin
                timer_r <= 16'd0;
            end else if (timer_r != TIMEOUT16) begin
                timer_r <= timer_r + 16'd1;
            end
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && start_s) begin
                frame_len_r <= (count_r >= MAX_CNT) ? MAX_LEN16 : 16'(count_r);
                sent_r      <= 16'd0;
            end else if (rd_en_s) begin
                sent_r <= sent_r + 16'd1;
            end
        end
    end

    // Send port registers; the read register doubles as the output data register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_r      <= 8'h00;
            len_r       <= 16'd0;
            last_r      <= 1'b0;
            valid_r     <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            data_r  <= rd_en_s ? mem_r[rd_ptr_r] : 8'h00;
            len_r   <= rd_en_s ? frame_len_r : 16'd0;
            last_r  <= last_rd_s;
            valid_r <= rd_en_s;
            if (last_rd_s) frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign bus.s_ready          = ready_r;
    assign bus.o_send_udp_data  = data_r;
    assign bus.o_send_udp_len   = len_r;
    assign bus.o_send_udp_last  = last_r;
    assign bus.o_send_udp_valid = valid_r;
    assign bus.o_frame_cnt      = frame_cnt_r;

    udp_tx_packetizer_chk u_chk (
        .clk   (i_clk),
        .rst_n (i_rst),
        .valid (valid_r),
        .last  (last_r),
        .len   (len_r)
    );
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scenario bench for udp_tx_packetizer: directed frame-cutting cases plus a randomized
// run scored against a byte-stream reference and the framing rules of the send port.
module tb_udp_tx_packetizer;
    localparam int MAXL  = 16;
    localparam int TMO   = 200;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    udp_tx_packetizer_if bus ();

    udp_tx_packetizer #(.P_MAX_LEN(MAXL), .P_TIMEOUT(TMO), .P_FIFO_DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int unsigned cyc = 0;
    int bad_idle = 0;
    int exp_frames = 0;

    logic [7:0]  obs_data[$];
    logic [15:0] obs_len[$];
    bit          obs_last[$];
    int unsigned obs_cyc[$];
    logic [7:0]  model_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Send-port recorder
    always @(negedge clk) begin
        if (bus.o_send_udp_valid === 1'b1) begin
            obs_data.push_back(bus.o_send_udp_data);
            obs_len.push_back(bus.o_send_udp_len);
            obs_last.push_back(bus.o_send_udp_last === 1'b1);
            obs_cyc.push_back(cyc);
        end else if (bus.o_send_udp_len !== 16'h0000 || bus.o_send_udp_last !== 1'b0) begin
            bad_idle++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_data.delete(); obs_len.delete(); obs_last.delete(); obs_cyc.delete();
        model_q.delete();
    endtask

    task automatic drive_byte(input logic [7:0] d, output bit acc);
        @(negedge clk);
        bus.i_flush = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        acc = (bus.s_ready === 1'b1);
        if (acc) model_q.push_back(d);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.i_flush = 1'b0;
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            idle_cycles(1);
            k++;
        end
    endtask

    // Counts framing violations in the recorded stream and returns the number of frames found
    function automatic int frame_errors(output int nframes);
        int s = 0;
        int errs = 0;
        int len;
        nframes = 0;
        while (s < obs_data.size()) begin
            len = int'(obs_len[s]);
            if (len == 0 || len > MAXL || s + len > obs_data.size()) begin
                errs++;
                break;
            end
            for (int k = 0; k < len; k++) begin
                if (int'(obs_len[s+k]) != len) errs++;
                if (obs_last[s+k] != (k == len - 1)) errs++;
                if (k > 0 && obs_cyc[s+k] != obs_cyc[s+k-1] + 1) errs++;
            end
            if (s > 0 && obs_cyc[s] < obs_cyc[s-1] + 2) errs++;
            nframes++;
            s += len;
        end
        return errs;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.i_flush = 1'b0; bus.i_send_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.s_ready, bus.o_send_udp_valid, bus.o_send_udp_last} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.s_ready, bus.o_send_udp_valid, bus.o_send_udp_last});
        else passes++;
        checks++;
        if ({bus.o_send_udp_len, bus.o_send_udp_data, bus.o_frame_cnt} !== 40'h0)
            $display("FAIL reset_buses: got len %h data %h cnt %h want 0", bus.o_send_udp_len, bus.o_send_udp_data, bus.o_frame_cnt);
        else passes++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", bus.s_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", bus.s_ready);
        else passes++;
        exp_frames = 0;
    endtask

    task automatic test_back_to_back();
        int i = 0;
        int g = 0;
        int errs = 0;
        bit acc;
        clear_obs();
        bus.i_send_ready = 1'b1;
        while (i < 40 && g < 200) begin
            drive_byte(8'(i), acc);
            if (acc) i++;
            g++;
        end
        wait_obs(32, 150);
        idle_cycles(5);
        checks++;
        if (obs_data.size() != 32) $display("FAIL b2b_first_two_size: got %0d want 32", obs_data.size());
        else passes++;
        for (int k = 0; k < obs_data.size() && k < 32; k++) begin
            if (obs_data[k] !== 8'(k)) errs++;
            if (obs_len[k] !== 16'd16) errs++;
            if (obs_last[k] != (k == 15 || k == 31)) errs++;
        end
        checks++;
        if (errs != 0) $display("FAIL b2b_first_two_content: got %0d errors want 0", errs);
        else passes++;
        checks++;
        if (bus.o_frame_cnt !== 16'd2) $display("FAIL b2b_cnt2: got %0d want 2", bus.o_frame_cnt);
        else passes++;
        idle_cycles(1000);
        errs = 0;
        checks++;
        if (obs_data.size() != 40) $display("FAIL b2b_tail_size: got %0d want 40", obs_data.size());
        else passes++;
        for (int k = 32; k < obs_data.size() && k < 40; k++) begin
            if (obs_data[k] !== 8'(k)) errs++;
            if (obs_len[k] !== 16'd8) errs++;
            if (obs_last[k] != (k == 39)) errs++;
        end
        checks++;
        if (errs != 0) $display("FAIL b2b_tail_content: got %0d errors want 0", errs);
        else passes++;
        exp_frames = 3;
        checks++;
        if (bus.o_frame_cnt !== 16'(exp_frames)) $display("FAIL b2b_cnt3: got %0d want %0d", bus.o_frame_cnt, exp_frames);
        else passes++;
    endtask

    task automatic test_flush_wait();
        bit acc;
        int unsigned c0;
        int errs = 0;
        clear_obs();
        bus.i_send_ready = 1'b0;
        for (int k = 0; k < 5; k++) drive_byte(8'($urandom), acc);
        pulse_flush();
        idle_cycles(50);
        checks++;
        if (obs_data.size() != 0) $display("FAIL flush_hold: got %0d bytes want 0", obs_data.size());
        else passes++;
        @(negedge clk);
        bus.i_send_ready = 1'b1;
        c0 = cyc;
        idle_cycles(30);
        checks++;
        if (obs_data.size() != 5) $display("FAIL flush_size: got %0d want 5", obs_data.size());
        else passes++;
        checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] != c0 + 2)
            $display("FAIL flush_latency: got first valid at cycle %0d want %0d", (obs_cyc.size() == 0) ? 0 : obs_cyc[0], c0 + 2);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < 5; k++) begin
            if (obs_data[k] !== model_q[k]) errs++;
            if (obs_len[k] !== 16'd5) errs++;
            if (obs_last[k] != (k == 4)) errs++;
        end
        checks++;
        if (errs != 0) $display("FAIL flush_content: got %0d errors want 0", errs);
        else passes++;
        exp_frames++;
        checks++;
        if (bus.o_frame_cnt !== 16'(exp_frames)) $display("FAIL flush_cnt: got %0d want %0d", bus.o_frame_cnt, exp_frames);
        else passes++;
    endtask

    task automatic test_fifo_full();
        logic [7:0] vals [DEPTH+10];
        int nxt = 0;
        int first_drop = -1;
        int g = 0;
        int nfr;
        int errs = 0;
        bit acc;
        clear_obs();
        for (int k = 0; k < DEPTH + 10; k++) vals[k] = 8'($urandom);
        bus.i_send_ready = 1'b0;
        for (int k = 0; k < DEPTH + 10; k++) begin
            drive_byte(vals[nxt], acc);
            if (acc) nxt++;
            else if (first_drop < 0) first_drop = nxt;
        end
        checks++;
        if (first_drop != DEPTH) $display("FAIL full_drop_point: got %0d want %0d", first_drop, DEPTH);
        else passes++;
        checks++;
        if (nxt != DEPTH || bus.s_ready !== 1'b0) $display("FAIL full_stall: got %0d accepted ready %b want %0d ready 0", nxt, bus.s_ready, DEPTH);
        else passes++;
        bus.i_send_ready = 1'b1;
        while (nxt < DEPTH + 10 && g < 400) begin
            drive_byte(vals[nxt], acc);
            if (acc) nxt++;
            g++;
        end
        wait_obs(DEPTH + 10, 800);
        idle_cycles(5);
        checks++;
        if (obs_data.size() != DEPTH + 10) $display("FAIL full_size: got %0d want %0d", obs_data.size(), DEPTH + 10);
        else passes++;
        for (int k = 0; k < obs_data.size() && k < DEPTH + 10; k++)
            if (obs_data[k] !== vals[k]) errs++;
        checks++;
        if (errs != 0) $display("FAIL full_order: got %0d errors want 0", errs);
        else passes++;
        errs = frame_errors(nfr);
        checks++;
        if (errs != 0 || nfr != 3) $display("FAIL full_framing: got %0d errors %0d frames want 0 errors 3 frames", errs, nfr);
        else passes++;
        exp_frames += 3;
        checks++;
        if (bus.o_frame_cnt !== 16'(exp_frames)) $display("FAIL full_cnt: got %0d want %0d", bus.o_frame_cnt, exp_frames);
        else passes++;
    endtask

    task automatic test_single_byte();
        bit acc;
        clear_obs();
        bus.i_send_ready = 1'b1;
        pulse_flush();
        idle_cycles(20);
        checks++;
        if (obs_data.size() != 0 || bus.o_frame_cnt !== 16'(exp_frames))
            $display("FAIL empty_flush: got %0d bytes cnt %0d want 0 bytes cnt %0d", obs_data.size(), bus.o_frame_cnt, exp_frames);
        else passes++;
        drive_byte(8'hA5, acc);
        pulse_flush();
        idle_cycles(20);
        checks++;
        if (obs_data.size() != 1) $display("FAIL single_size: got %0d want 1", obs_data.size());
        else passes++;
        checks++;
        if (obs_data.size() != 1 || {obs_data[0], obs_len[0], obs_last[0]} !== {8'hA5, 16'd1, 1'b1})
            $display("FAIL single_beat: got data %h len %0d last %0d want a5 1 1",
                     (obs_data.size() > 0) ? obs_data[0] : 8'h00, (obs_len.size() > 0) ? obs_len[0] : 16'h0, (obs_last.size() > 0) ? obs_last[0] : 1'b0);
        else passes++;
        exp_frames++;
        checks++;
        if (bus.o_frame_cnt !== 16'(exp_frames)) $display("FAIL single_cnt: got %0d want %0d", bus.o_frame_cnt, exp_frames);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int i = 0;
        int g = 0;
        int lasts = 0;
        bit acc;
        clear_obs();
        bus.i_send_ready = 1'b1;
        while (i < 16 && g < 100) begin
            drive_byte(8'(8'h40 + i), acc);
            if (acc) i++;
            g++;
        end
        g = 0;
        while (obs_data.size() < 7 && g < 100) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            #1;
            g++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_send_udp_valid, bus.o_send_udp_last, bus.s_ready, bus.o_send_udp_len, bus.o_send_udp_data, bus.o_frame_cnt} !== 43'h0)
            $display("FAIL midreset_outputs: got valid %b last %b ready %b len %0d data %h cnt %0d want all 0",
                     bus.o_send_udp_valid, bus.o_send_udp_last, bus.s_ready, bus.o_send_udp_len, bus.o_send_udp_data, bus.o_frame_cnt);
        else passes++;
        exp_frames = 0;
        foreach (obs_last[k]) if (obs_last[k]) lasts++;
        checks++;
        if (obs_data.size() != 7 || lasts != 0) $display("FAIL midreset_partial: got %0d bytes %0d lasts want 7 bytes 0 lasts", obs_data.size(), lasts);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(300);
        checks++;
        if (obs_data.size() != 7 || bus.o_frame_cnt !== 16'd0 || bus.s_ready !== 1'b1)
            $display("FAIL midreset_quiet: got %0d bytes cnt %0d ready %b want 7 bytes cnt 0 ready 1", obs_data.size(), bus.o_frame_cnt, bus.s_ready);
        else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        int nfr;
        bit acc;
        clear_obs();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            bus.i_send_ready = 1'($urandom_range(0, 1));
            bus.i_flush = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) < 7) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'($urandom);
                acc = (bus.s_ready === 1'b1);
                if (acc) model_q.push_back(bus.s_data);
            end else begin
                bus.s_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_send_ready = 1'b1;
        wait_obs(model_q.size(), 800);
        idle_cycles(10);
        checks++;
        if (obs_data.size() != model_q.size()) $display("FAIL rand_size: got %0d want %0d", obs_data.size(), model_q.size());
        else passes++;
        for (int k = 0; k < obs_data.size() && k < model_q.size(); k++)
            if (obs_data[k] !== model_q[k]) errs++;
        checks++;
        if (errs != 0) $display("FAIL rand_order: got %0d errors want 0", errs);
        else passes++;
        errs = frame_errors(nfr);
        checks++;
        if (errs != 0) $display("FAIL rand_framing: got %0d errors want 0", errs);
        else passes++;
        checks++;
        if (bus.o_frame_cnt !== 16'(exp_frames + nfr)) $display("FAIL rand_cnt: got %0d want %0d", bus.o_frame_cnt, exp_frames + nfr);
        else passes++;
        checks++;
        if (bad_idle != 0) $display("FAIL idle_quiet: got %0d bad idle cycles want 0", bad_idle);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flush_wait();
        test_fifo_full();
        test_single_byte();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
